// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator keypad datapath.
package calc_pkg;

  localparam logic [3:0] KEY_SIGN      = 4'hA;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

  typedef enum logic {
    IDLE,
    CONV
  } conv_state_e;

  typedef logic [3:0] bcd_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first, saturating.
// The SIGNED_MAG parameter limits the magnitude and applies two's complement on completion.
module bcd_to_bin_seq
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned VALUE_W    = 16,
  parameter bit          SIGNED_MAG = 1'b0,
  localparam int unsigned IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_start,
  input  logic               i_neg,
  input  bcd_t               i_digit,
  output logic [IDX_W-1:0]   o_idx,
  output logic [VALUE_W-1:0] o_value,
  output logic               o_overflow,
  output logic               o_valid
);

  localparam int unsigned ACC_W = VALUE_W + 4;
  localparam logic [ACC_W-1:0] MAX_VAL = SIGNED_MAG ?
      ((ACC_W'(1) << (VALUE_W - 1)) - ACC_W'(1)) :
      ((ACC_W'(1) << VALUE_W) - ACC_W'(1));
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

  conv_state_e        r_state, w_state_d;
  logic [ACC_W-1:0]   r_acc, w_acc_d;
  logic               r_sat, w_sat_d;
  logic [IDX_W-1:0]   r_idx, w_idx_d;
  logic [VALUE_W-1:0] r_value, w_value_d;
  logic               r_overflow, w_overflow_d;

  logic [ACC_W-1:0]   w_sum;
  logic               w_step_sat;
  logic [ACC_W-1:0]   w_step_acc;
  logic [VALUE_W-1:0] w_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_sat      <= 1'b0;
      r_idx      <= '0;
      r_value    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_acc      <= w_acc_d;
      r_sat      <= w_sat_d;
      r_idx      <= w_idx_d;
      r_value    <= w_value_d;
      r_overflow <= w_overflow_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_acc_d      = r_acc;
    w_sat_d      = r_sat;
    w_idx_d      = r_idx;
    w_value_d    = r_value;
    w_overflow_d = r_overflow;

    // r_acc never exceeds MAX_VAL, so acc*10+9 always fits in ACC_W bits
    w_sum      = r_acc * ACC_W'(10) + ACC_W'(i_digit);
    w_step_sat = r_sat | (w_sum > MAX_VAL);
    w_step_acc = w_step_sat ? MAX_VAL : w_sum;
    w_mag      = w_step_acc[VALUE_W-1:0];

    if (i_clear) begin
      w_state_d    = IDLE;
      w_acc_d      = '0;
      w_sat_d      = 1'b0;
      w_idx_d      = '0;
      w_value_d    = '0;
      w_overflow_d = 1'b0;
    end else if (i_start) begin
      w_state_d = CONV;
      w_acc_d   = '0;
      w_sat_d   = 1'b0;
      w_idx_d   = IDX_TOP;
    end else if (r_state == CONV) begin
      w_acc_d = w_step_acc;
      w_sat_d = w_step_sat;
      w_idx_d = r_idx - IDX_W'(1);
      if (r_idx == '0) begin
        w_state_d    = IDLE;
        w_value_d    = i_neg ? (~w_mag + VALUE_W'(1)) : w_mag;
        w_overflow_d = w_step_sat;
      end
    end
  end

  assign o_idx      = r_idx;
  assign o_value    = r_value;
  assign o_overflow = r_overflow;
  assign o_valid    = (r_state == IDLE);

endmodule

// File: rtl/digit_entry_register.sv
// Keypad digit-entry register: edge detect, BCD digit shifter and count, feeding a
// sequential binary converter. Define DIGIT_ENTRY_SIGN_EN to add the sign key and `negative`.
module digit_entry_register
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned VALUE_W = 16,
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  erase,
  input  logic                  backspace,
  input  logic [3:0]            num,
  input  logic                  numPressed,
  output logic [4*DIGITS-1:0]   digits,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic [VALUE_W-1:0]    value,
  output logic                  overflow,
  output logic                  valid
`ifdef DIGIT_ENTRY_SIGN_EN
  ,
  output logic                  negative
`endif
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef DIGIT_ENTRY_SIGN_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif

  logic                r_num_q;
  logic                r_bksp_q;
  logic [4*DIGITS-1:0] r_digits, w_digits_d;
  logic [CNT_W-1:0]    r_count, w_count_d;
  logic                w_press;
  logic                w_bksp;
  logic                w_full;
  logic                w_start;
  logic                w_neg;
  logic [4*DIGITS-1:0] w_num_ext;
  logic [IDX_W-1:0]    w_idx;
  bcd_t                w_digit;

`ifdef DIGIT_ENTRY_SIGN_EN
  logic r_negative, w_negative_d;
  assign w_neg    = r_negative;
  assign negative = r_negative;
`else
  assign w_neg = 1'b0;
`endif

  assign w_press = numPressed & ~r_num_q;
  assign w_bksp  = backspace & ~r_bksp_q;
  assign w_full  = (r_count == CNT_W'(DIGITS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_num_q    <= 1'b0;
      r_bksp_q   <= 1'b0;
      r_digits   <= '0;
      r_count    <= '0;
`ifdef DIGIT_ENTRY_SIGN_EN
      r_negative <= 1'b0;
`endif
    end else begin
      r_num_q    <= numPressed;
      r_bksp_q   <= backspace;
      r_digits   <= w_digits_d;
      r_count    <= w_count_d;
`ifdef DIGIT_ENTRY_SIGN_EN
      r_negative <= w_negative_d;
`endif
    end
  end

  // erase > backspace > press; lower-priority events in the same cycle are dropped
  always_comb begin
    w_digits_d     = r_digits;
    w_count_d      = r_count;
    w_start        = 1'b0;
    w_num_ext      = '0;
    w_num_ext[3:0] = num;
`ifdef DIGIT_ENTRY_SIGN_EN
    w_negative_d   = r_negative;
`endif

    if (erase) begin
      w_digits_d = '0;
      w_count_d  = '0;
`ifdef DIGIT_ENTRY_SIGN_EN
      w_negative_d = 1'b0;
`endif
    end else if (w_bksp) begin
      if (r_count != '0) begin
        w_digits_d = r_digits >> 4;
        w_count_d  = r_count - CNT_W'(1);
        w_start    = 1'b1;
      end
    end else if (w_press) begin
      if (is_digit(num)) begin
        // no leading zeros: a zero as the first key is dropped
        if (!w_full && !(r_count == '0 && num == 4'd0)) begin
          w_digits_d = (r_digits << 4) | w_num_ext;
          w_count_d  = r_count + CNT_W'(1);
          w_start    = 1'b1;
        end
      end
`ifdef DIGIT_ENTRY_SIGN_EN
      else if (num == KEY_SIGN) begin
        w_negative_d = ~r_negative;
        w_start      = 1'b1;
      end
`endif
    end
  end

  assign w_digit = r_digits[4*w_idx +: 4];

  bcd_to_bin_seq #(
    .DIGITS     (DIGITS),
    .VALUE_W    (VALUE_W),
    .SIGNED_MAG (SIGN_EN)
  ) u_conv (
    .clk        (clk),
    .rst_n      (reset),
    .i_clear    (erase),
    .i_start    (w_start),
    .i_neg      (w_neg),
    .i_digit    (w_digit),
    .o_idx      (w_idx),
    .o_value    (value),
    .o_overflow (overflow),
    .o_valid    (valid)
  );

  assign digits = r_digits;
  assign count  = r_count;
  assign full   = w_full;

endmodule
